// File: rtl/mci_pkg.sv
// mci_pkg: shared widths, scrub FSM state type and SECDED(39,32) helper
// functions for the MCI SRAM ECC path.
//   Codeword layout: {ecc[6:0], data[31:0]}
//     ecc[5:0] = Hamming check bits (classic positions 1,2,4,8,16,32)
//     ecc[6]   = overall parity across data and ecc[5:0]
package mci_pkg;

    localparam int MCI_SRAM_DATA_W = 32;
    localparam int MCI_SRAM_ECC_W  = 7;
    localparam int MCI_SRAM_CW_W   = MCI_SRAM_DATA_W + MCI_SRAM_ECC_W;
    localparam int MCI_SRAM_HAM_W  = MCI_SRAM_ECC_W - 1;

    typedef enum logic {
        MCI_ST_IDLE = 1'b0,
        MCI_ST_WB   = 1'b1
    } mci_sram_state_e;

    // Hamming position (3..38) of data bit idx: the idx-th position that is
    // not a power of two. Constant-folds for constant idx.
    function automatic logic [5:0] mci_data_pos(input int idx);
        logic [5:0] pos;
        int         cnt;
        pos = '0;
        cnt = 0;
        for (int p = 3; p < MCI_SRAM_CW_W; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == idx) pos = p[5:0];
                cnt = cnt + 1;
            end
        end
        return pos;
    endfunction

    // Hamming check bits over the 32 data bits.
    function automatic logic [MCI_SRAM_HAM_W-1:0] mci_hamming(
        input logic [MCI_SRAM_DATA_W-1:0] d
    );
        logic [MCI_SRAM_HAM_W-1:0] c;
        logic [5:0]                pos;
        c = '0;
        for (int i = 0; i < MCI_SRAM_DATA_W; i++) begin
            pos = mci_data_pos(i);
            for (int j = 0; j < MCI_SRAM_HAM_W; j++) begin
                if (pos[j]) c[j] = c[j] ^ d[i];
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/mci_sram_secded.sv
// mci_sram_secded: combinational SECDED(39,32) encoder and decoder.
//   i_enc_data  in  32  data to encode
//   o_enc_cw    out 39  encoded codeword
//   i_dec_cw    in  39  codeword to check
//   o_dec_data  out 32  corrected data (raw data on uncorrectable error)
//   o_dec_cw    out 39  corrected codeword (raw on uncorrectable error)
//   o_sb        out 1   single-bit error corrected
//   o_db        out 1   uncorrectable error detected
module mci_sram_secded
    import mci_pkg::*;
(
    input  logic [MCI_SRAM_DATA_W-1:0] i_enc_data,
    output logic [MCI_SRAM_CW_W-1:0]   o_enc_cw,
    input  logic [MCI_SRAM_CW_W-1:0]   i_dec_cw,
    output logic [MCI_SRAM_DATA_W-1:0] o_dec_data,
    output logic [MCI_SRAM_CW_W-1:0]   o_dec_cw,
    output logic                       o_sb,
    output logic                       o_db
);

    logic [MCI_SRAM_HAM_W-1:0] w_enc_chk;
    logic [MCI_SRAM_HAM_W-1:0] w_syn;
    logic                      w_par;
    logic                      w_hit;
    logic [MCI_SRAM_CW_W-1:0]  w_flip;

    assign w_enc_chk = mci_hamming(i_enc_data);
    assign o_enc_cw  = {^{w_enc_chk, i_enc_data}, w_enc_chk, i_enc_data};

    // Syndrome names the Hamming position of a single flipped bit; overall
    // parity separates odd (correctable) from even (double) error counts.
    assign w_syn = mci_hamming(i_dec_cw[MCI_SRAM_DATA_W-1:0])
                 ^ i_dec_cw[MCI_SRAM_DATA_W +: MCI_SRAM_HAM_W];
    assign w_par = ^i_dec_cw;

    always_comb begin
        w_flip = '0;
        w_hit  = 1'b0;
        o_sb   = 1'b0;
        o_db   = 1'b0;
        if (w_par) begin
            if (w_syn == '0) begin
                // only the overall parity bit itself flipped
                w_flip[MCI_SRAM_CW_W-1] = 1'b1;
                w_hit = 1'b1;
            end else if ((w_syn & (w_syn - 6'd1)) == '0) begin
                // power-of-two syndrome: a Hamming check bit flipped
                for (int j = 0; j < MCI_SRAM_HAM_W; j++) begin
                    if (w_syn[j]) w_flip[MCI_SRAM_DATA_W + j] = 1'b1;
                end
                w_hit = 1'b1;
            end else begin
                for (int i = 0; i < MCI_SRAM_DATA_W; i++) begin
                    if (mci_data_pos(i) == w_syn) begin
                        w_flip[i] = 1'b1;
                        w_hit     = 1'b1;
                    end
                end
            end
            // odd parity but syndrome beyond position 38: multi-bit, not fixable
            o_sb = w_hit;
            o_db = ~w_hit;
        end else if (w_syn != '0) begin
            o_db = 1'b1;
        end
    end

    assign o_dec_cw   = i_dec_cw ^ w_flip;
    assign o_dec_data = o_dec_cw[MCI_SRAM_DATA_W-1:0];

endmodule

// File: rtl/mci_sram_ecc_scrub.sv
// mci_sram_ecc_scrub: SECDED wrapper between the MCI SRAM request port and a
// 39-bit SRAM macro, with single-bit error scrubbing (corrected write-back).
//   clk, mci_rst_b             clock, async active-low reset
//   req_cs/we/addr/wdata       upstream request; accepted when req_hold=0
//   req_hold                   request stalled (write-back pending/active)
//   req_rvalid/req_rdata       corrected read data, one cycle after accept
//   sram_cs/we/addr/wdata      macro control and encoded write codeword
//   sram_rdata                 macro codeword, one cycle after a read select
//   scrub_en                   write corrected codeword back on single-bit error
//   cnt_clr                    clear single-bit error counter (wins over inc)
//   ecc_sb_err/ecc_db_err      one-cycle error pulses with read data
//   ecc_err_addr               address of the latest erroring read
//   sb_err_cnt                 saturating single-bit error count
module mci_sram_ecc_scrub
    import mci_pkg::*;
#(
    parameter int ADDR_W = 17,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       mci_rst_b,
    input  logic                       req_cs,
    input  logic                       req_we,
    input  logic [ADDR_W-1:0]          req_addr,
    input  logic [MCI_SRAM_DATA_W-1:0] req_wdata,
    output logic                       req_hold,
    output logic                       req_rvalid,
    output logic [MCI_SRAM_DATA_W-1:0] req_rdata,
    output logic                       sram_cs,
    output logic                       sram_we,
    output logic [ADDR_W-1:0]          sram_addr,
    output logic [MCI_SRAM_CW_W-1:0]   sram_wdata,
    input  logic [MCI_SRAM_CW_W-1:0]   sram_rdata,
    input  logic                       scrub_en,
    input  logic                       cnt_clr,
    output logic                       ecc_sb_err,
    output logic                       ecc_db_err,
    output logic [ADDR_W-1:0]          ecc_err_addr,
    output logic [CNT_W-1:0]           sb_err_cnt
);

    mci_sram_state_e            r_state, w_state_nxt;
    logic                       r_rd_pend;
    logic [ADDR_W-1:0]          r_rd_addr;
    logic [ADDR_W-1:0]          r_wb_addr;
    logic [MCI_SRAM_CW_W-1:0]   r_wb_cw;
    logic [ADDR_W-1:0]          r_err_addr;
    logic [CNT_W-1:0]           r_sb_cnt;

    logic [MCI_SRAM_CW_W-1:0]   w_enc_cw;
    logic [MCI_SRAM_DATA_W-1:0] w_dec_data;
    logic [MCI_SRAM_CW_W-1:0]   w_dec_cw;
    logic                       w_dec_sb, w_dec_db;
    logic                       w_sb, w_db;
    logic                       w_wb_sched;
    logic                       w_accept;

    mci_sram_secded u_secded (
        .i_enc_data (req_wdata),
        .o_enc_cw   (w_enc_cw),
        .i_dec_cw   (sram_rdata),
        .o_dec_data (w_dec_data),
        .o_dec_cw   (w_dec_cw),
        .o_sb       (w_dec_sb),
        .o_db       (w_dec_db)
    );

    // Decoder flags only mean something in the cycle the macro returns data.
    assign w_sb = r_rd_pend & w_dec_sb;
    assign w_db = r_rd_pend & w_dec_db;

    always_ff @(posedge clk or negedge mci_rst_b) begin
        if (!mci_rst_b) r_state <= MCI_ST_IDLE;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wb_sched  = 1'b0;
        req_hold    = 1'b0;
        w_accept    = 1'b0;
        sram_cs     = 1'b0;
        sram_we     = 1'b0;
        sram_addr   = '0;
        sram_wdata  = '0;
        case (r_state)
            MCI_ST_IDLE: begin
                if (w_sb && scrub_en) begin
                    w_wb_sched  = 1'b1;
                    w_state_nxt = MCI_ST_WB;
                end
            end
            MCI_ST_WB: w_state_nxt = MCI_ST_IDLE;
            default:   w_state_nxt = MCI_ST_IDLE;
        endcase
        // Stall from the detect cycle so the write-back slot is never
        // contended by a new request.
        req_hold = w_wb_sched | (r_state == MCI_ST_WB);
        w_accept = req_cs & ~req_hold;
        if (r_state == MCI_ST_WB) begin
            sram_cs    = 1'b1;
            sram_we    = 1'b1;
            sram_addr  = r_wb_addr;
            sram_wdata = r_wb_cw;
        end else if (w_accept) begin
            sram_cs    = 1'b1;
            sram_we    = req_we;
            sram_addr  = req_addr;
            sram_wdata = req_we ? w_enc_cw : '0;
        end
    end

    always_ff @(posedge clk or negedge mci_rst_b) begin
        if (!mci_rst_b) begin
            r_rd_pend  <= 1'b0;
            r_rd_addr  <= '0;
            r_wb_addr  <= '0;
            r_wb_cw    <= '0;
            r_err_addr <= '0;
            r_sb_cnt   <= '0;
        end else begin
            r_rd_pend <= w_accept & ~req_we;
            if (w_accept) r_rd_addr <= req_addr;
            if (w_wb_sched) begin
                r_wb_addr <= r_rd_addr;
                r_wb_cw   <= w_dec_cw;
            end
            if (w_sb || w_db) r_err_addr <= r_rd_addr;
            if (cnt_clr)
                r_sb_cnt <= '0;
            else if (w_sb && (r_sb_cnt != '1))
                r_sb_cnt <= r_sb_cnt + 1'b1;
        end
    end

    assign req_rvalid   = r_rd_pend;
    assign req_rdata    = r_rd_pend ? w_dec_data : '0;
    assign ecc_sb_err   = w_sb;
    assign ecc_db_err   = w_db;
    assign ecc_err_addr = r_err_addr;
    assign sb_err_cnt   = r_sb_cnt;

endmodule

// File: tb/tb_mci_sram_ecc_scrub.sv
module tb_mci_sram_ecc_scrub;

    localparam int AW = 17;
    localparam int CW = 4;

    // Hand-computed codewords: data 0 -> all zero; data 1 -> data bit 0 sits at
    // Hamming position 3 (chk0,chk1) plus overall parity -> ecc 7'h43.
    localparam logic [38:0] CW_ONE = 39'h43_0000_0001;

    logic          clk = 1'b0;
    logic          mci_rst_b = 1'b0;
    logic          req_cs = 1'b0, req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic          req_hold, req_rvalid;
    logic [31:0]   req_rdata;
    logic          sram_cs, sram_we;
    logic [AW-1:0] sram_addr;
    logic [38:0]   sram_wdata;
    logic [38:0]   sram_rdata = '0;
    logic          scrub_en = 1'b0, cnt_clr = 1'b0;
    logic          ecc_sb_err, ecc_db_err;
    logic [AW-1:0] ecc_err_addr;
    logic [CW-1:0] sb_err_cnt;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [38:0] mem [0:255];
    int          wr_cnt = 0;

    always #5 clk = ~clk;

    mci_sram_ecc_scrub #(.ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .mci_rst_b(mci_rst_b),
        .req_cs(req_cs), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_hold(req_hold), .req_rvalid(req_rvalid), .req_rdata(req_rdata),
        .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .scrub_en(scrub_en), .cnt_clr(cnt_clr),
        .ecc_sb_err(ecc_sb_err), .ecc_db_err(ecc_db_err),
        .ecc_err_addr(ecc_err_addr), .sb_err_cnt(sb_err_cnt)
    );

    // SRAM macro model: one-cycle read latency, writes counted.
    initial for (int i = 0; i < 256; i++) mem[i] = '0;
    always @(posedge clk) begin
        if (sram_cs) begin
            if (sram_we) begin
                mem[sram_addr[7:0]] <= sram_wdata;
                wr_cnt <= wr_cnt + 1;
            end else begin
                sram_rdata <= mem[sram_addr[7:0]];
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d);
        req_cs = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
        tick();
        req_cs = 1'b0; req_we = 1'b0;
    endtask

    task automatic test_reset();
        mci_rst_b = 1'b0;
        tick(); tick();
        @(negedge clk);
        total_cnt++;
        if ({req_hold, req_rvalid, sram_cs, ecc_sb_err, ecc_db_err} !== 5'b0)
            $display("FAIL reset_ctrl got %b want 00000", {req_hold, req_rvalid, sram_cs, ecc_sb_err, ecc_db_err});
        else pass_cnt++;
        total_cnt++;
        if (sb_err_cnt !== 4'h0 || ecc_err_addr !== 17'h0)
            $display("FAIL reset_regs cnt %h addr %h want 0 0", sb_err_cnt, ecc_err_addr);
        else pass_cnt++;
        mci_rst_b = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        // write DEADBEEF @0x10, check macro side in the accept cycle
        req_cs = 1'b1; req_we = 1'b1; req_addr = 17'h10; req_wdata = 32'hDEADBEEF;
        @(negedge clk);
        total_cnt++;
        if ({sram_cs, sram_we, req_hold} !== 3'b110 || sram_addr !== 17'h10)
            $display("FAIL wr_ctrl cs/we/hold %b addr %h want 110 10", {sram_cs, sram_we, req_hold}, sram_addr);
        else pass_cnt++;
        tick();
        req_cs = 1'b0; req_we = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (req_rvalid !== 1'b0 || sram_cs !== 1'b0)
            $display("FAIL wr_no_rvalid rvalid %b cs %b want 0 0", req_rvalid, sram_cs);
        else pass_cnt++;
        // encoder vectors
        req_cs = 1'b1; req_we = 1'b1; req_addr = 17'h11; req_wdata = 32'h1;
        @(negedge clk);
        total_cnt++;
        if (sram_wdata !== CW_ONE)
            $display("FAIL enc_one got %h want %h", sram_wdata, CW_ONE);
        else pass_cnt++;
        tick();
        req_addr = 17'h12; req_wdata = 32'h0;
        @(negedge clk);
        total_cnt++;
        if (sram_wdata !== 39'h0)
            $display("FAIL enc_zero got %h want 0", sram_wdata);
        else pass_cnt++;
        tick();
        req_cs = 1'b0; req_we = 1'b0;
        // read back @0x10
        req_cs = 1'b1; req_addr = 17'h10;
        @(negedge clk);
        total_cnt++;
        if ({sram_cs, sram_we} !== 2'b10 || sram_addr !== 17'h10)
            $display("FAIL rd_ctrl cs/we %b addr %h want 10 10", {sram_cs, sram_we}, sram_addr);
        else pass_cnt++;
        tick();
        req_cs = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (req_rvalid !== 1'b1 || req_rdata !== 32'hDEADBEEF || ecc_sb_err !== 1'b0 || ecc_db_err !== 1'b0)
            $display("FAIL rd_clean rvalid %b data %h sb %b db %b want 1 deadbeef 0 0",
                     req_rvalid, req_rdata, ecc_sb_err, ecc_db_err);
        else pass_cnt++;
        tick();
        @(negedge clk);
        total_cnt++;
        if (req_rvalid !== 1'b0)
            $display("FAIL rd_one_cycle rvalid %b want 0", req_rvalid);
        else pass_cnt++;
        // check-bit error (ecc[1]) @0x11 with scrubbing off
        mem[8'h11][33] = ~mem[8'h11][33];
        tick();
        req_cs = 1'b1; req_addr = 17'h11;
        tick();
        req_cs = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (req_rdata !== 32'h1 || ecc_sb_err !== 1'b1 || req_hold !== 1'b0)
            $display("FAIL chk_bit_err data %h sb %b hold %b want 1 1 0", req_rdata, ecc_sb_err, req_hold);
        else pass_cnt++;
        tick();
        @(negedge clk);
        total_cnt++;
        if (sb_err_cnt !== 4'h1 || ecc_err_addr !== 17'h11 || sram_cs !== 1'b0)
            $display("FAIL chk_bit_after cnt %h addr %h cs %b want 1 11 0", sb_err_cnt, ecc_err_addr, sram_cs);
        else pass_cnt++;
    endtask

    task automatic test_sb_scrub();
        do_write(17'h20, 32'h1);
        mem[8'h20][5] = ~mem[8'h20][5];
        scrub_en = 1'b1;
        req_cs = 1'b1; req_addr = 17'h20;          // N
        tick();
        req_addr = 17'h10;                         // N+1: new read, must stall
        @(negedge clk);
        total_cnt++;
        if (req_rvalid !== 1'b1 || req_rdata !== 32'h1 || ecc_sb_err !== 1'b1)
            $display("FAIL sb_data rvalid %b data %h sb %b want 1 1 1", req_rvalid, req_rdata, ecc_sb_err);
        else pass_cnt++;
        total_cnt++;
        if (req_hold !== 1'b1 || sram_cs !== 1'b0)
            $display("FAIL sb_hold1 hold %b cs %b want 1 0", req_hold, sram_cs);
        else pass_cnt++;
        tick();                                    // N+2: write-back
        @(negedge clk);
        total_cnt++;
        if (req_hold !== 1'b1 || {sram_cs, sram_we} !== 2'b11 || sram_addr !== 17'h20 || sram_wdata !== CW_ONE)
            $display("FAIL sb_wb hold %b cs/we %b addr %h cw %h want 1 11 20 %h",
                     req_hold, {sram_cs, sram_we}, sram_addr, sram_wdata, CW_ONE);
        else pass_cnt++;
        total_cnt++;
        if (ecc_err_addr !== 17'h20 || sb_err_cnt !== 4'h2 || ecc_sb_err !== 1'b0 || req_rvalid !== 1'b0)
            $display("FAIL sb_status addr %h cnt %h sb %b rvalid %b want 20 2 0 0",
                     ecc_err_addr, sb_err_cnt, ecc_sb_err, req_rvalid);
        else pass_cnt++;
        tick();                                    // N+3: stalled read goes
        @(negedge clk);
        total_cnt++;
        if (req_hold !== 1'b0 || {sram_cs, sram_we} !== 2'b10 || sram_addr !== 17'h10)
            $display("FAIL sb_resume hold %b cs/we %b addr %h want 0 10 10", req_hold, {sram_cs, sram_we}, sram_addr);
        else pass_cnt++;
        tick();
        req_cs = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (req_rvalid !== 1'b1 || req_rdata !== 32'hDEADBEEF)
            $display("FAIL sb_resume_data rvalid %b data %h want 1 deadbeef", req_rvalid, req_rdata);
        else pass_cnt++;
        total_cnt++;
        if (mem[8'h20] !== CW_ONE)
            $display("FAIL sb_mem_fixed got %h want %h", mem[8'h20], CW_ONE);
        else pass_cnt++;
        tick();
        req_cs = 1'b1; req_addr = 17'h20;
        tick();
        req_cs = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (req_rdata !== 32'h1 || ecc_sb_err !== 1'b0 || req_hold !== 1'b0)
            $display("FAIL sb_reread data %h sb %b hold %b want 1 0 0", req_rdata, ecc_sb_err, req_hold);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_db();
        int wr0;
        do_write(17'h30, 32'h12345678);
        mem[8'h30][3] = ~mem[8'h30][3];
        mem[8'h30][9] = ~mem[8'h30][9];
        wr0 = wr_cnt;
        req_cs = 1'b1; req_addr = 17'h30;
        tick();
        req_cs = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (ecc_db_err !== 1'b1 || ecc_sb_err !== 1'b0 || req_rdata !== 32'h12345470 || req_hold !== 1'b0)
            $display("FAIL db_pulse db %b sb %b data %h hold %b want 1 0 12345470 0",
                     ecc_db_err, ecc_sb_err, req_rdata, req_hold);
        else pass_cnt++;
        tick(); tick();
        @(negedge clk);
        total_cnt++;
        if (ecc_err_addr !== 17'h30 || sb_err_cnt !== 4'h2 || wr_cnt !== wr0)
            $display("FAIL db_after addr %h cnt %h writes %0d want 30 2 %0d", ecc_err_addr, sb_err_cnt, wr_cnt, wr0);
        else pass_cnt++;
    endtask

    task automatic test_saturate();
        int bad;
        scrub_en = 1'b0;
        do_write(17'h40, 32'h0);
        mem[8'h40][0] = 1'b1;
        bad = 0;
        for (int k = 0; k <= 16; k++) begin        // 16 back-to-back reads
            req_cs = (k < 16); req_addr = 17'h40;
            @(negedge clk);
            if (req_hold !== 1'b0) bad++;
            if (k > 0 && (req_rvalid !== 1'b1 || ecc_sb_err !== 1'b1 || req_rdata !== 32'h0)) bad++;
            tick();
        end
        req_cs = 1'b0;
        total_cnt++;
        if (bad !== 0)
            $display("FAIL b2b_reads bad cycles %0d want 0", bad);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (sb_err_cnt !== 4'hF)
            $display("FAIL cnt_sat got %h want f", sb_err_cnt);
        else pass_cnt++;
        req_cs = 1'b1;
        tick();
        req_cs = 1'b0; cnt_clr = 1'b1;             // clear while error pulses
        @(negedge clk);
        total_cnt++;
        if (ecc_sb_err !== 1'b1)
            $display("FAIL clr_concurrent_err sb %b want 1", ecc_sb_err);
        else pass_cnt++;
        tick();
        cnt_clr = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (sb_err_cnt !== 4'h0)
            $display("FAIL cnt_clr_prio got %h want 0", sb_err_cnt);
        else pass_cnt++;
        req_cs = 1'b1;
        tick();
        req_cs = 1'b0;
        tick();
        @(negedge clk);
        total_cnt++;
        if (sb_err_cnt !== 4'h1)
            $display("FAIL cnt_after_clr got %h want 1", sb_err_cnt);
        else pass_cnt++;
    endtask

    task automatic test_reset_wb();
        int wr0;
        do_write(17'h50, 32'h1);
        mem[8'h50][7] = ~mem[8'h50][7];
        scrub_en = 1'b1;
        req_cs = 1'b1; req_addr = 17'h50;
        tick();
        req_cs = 1'b0;
        tick();                                    // in WB
        @(negedge clk);
        wr0 = wr_cnt;
        total_cnt++;
        if ({sram_cs, sram_we} !== 2'b11)
            $display("FAIL rst_wb_active cs/we %b want 11", {sram_cs, sram_we});
        else pass_cnt++;
        #1 mci_rst_b = 1'b0;
        #1;
        total_cnt++;
        if ({sram_cs, sram_we, req_hold, req_rvalid, ecc_sb_err} !== 5'b0 ||
            sb_err_cnt !== 4'h0 || ecc_err_addr !== 17'h0)
            $display("FAIL rst_wb_outputs ctl %b cnt %h addr %h want 00000 0 0",
                     {sram_cs, sram_we, req_hold, req_rvalid, ecc_sb_err}, sb_err_cnt, ecc_err_addr);
        else pass_cnt++;
        tick(); tick();
        mci_rst_b = 1'b1;
        tick(); tick(); tick();
        @(negedge clk);
        total_cnt++;
        if (wr_cnt !== wr0 || mem[8'h50] !== (CW_ONE ^ 39'h80) || req_hold !== 1'b0 || sram_cs !== 1'b0)
            $display("FAIL rst_wb_no_write writes %0d mem %h hold %b cs %b want %0d %h 0 0",
                     wr_cnt, mem[8'h50], req_hold, sram_cs, wr0, CW_ONE ^ 39'h80);
        else pass_cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_sb_scrub();
        test_db();
        test_saturate();
        test_reset_wb();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mci_sram_ecc_scrub.md
MCI_SRAM_ECC_SCRUB -- requirements
Module: mci_sram_ecc_scrub

Interface
REQ-001 SHALL have parameter ADDR_W, default 17, meaning SRAM word-address width (512 KB of 32-bit words).
REQ-002 SHALL have parameter CNT_W, default 16, meaning single-bit error counter width.
REQ-003 SHALL have port clk  in  1  sole clock; all state on its rising edge.
REQ-004 SHALL have port mci_rst_b  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_cs  in  1  upstream (mci_top SRAM request side) access request.
REQ-006 SHALL have port req_we  in  1  1 = write, 0 = read.
REQ-007 SHALL have port req_addr  in  ADDR_W  word address.
REQ-008 SHALL have port req_wdata  in  32  write data, full word only.
REQ-009 SHALL have port req_hold  out  1  request not accepted this cycle.
REQ-010 SHALL have port req_rvalid  out  1  read data valid.
REQ-011 SHALL have port req_rdata  out  32  corrected read data.
REQ-012 SHALL have port sram_cs  out  1  macro chip select.
REQ-013 SHALL have port sram_we  out  1  macro write enable.
REQ-014 SHALL have port sram_addr  out  ADDR_W  macro address.
REQ-015 SHALL have port sram_wdata  out  39  codeword {ecc[6:0], data[31:0]}.
REQ-016 SHALL have port sram_rdata  in  39  codeword, valid one cycle after a read select.
REQ-017 SHALL have port scrub_en  in  1  enable corrected write-back.
REQ-018 SHALL have port cnt_clr  in  1  clear single-bit counter.
REQ-019 SHALL have port ecc_sb_err  out  1  one-cycle pulse, corrected error.
REQ-020 SHALL have port ecc_db_err  out  1  one-cycle pulse, uncorrectable error.
REQ-021 SHALL have port ecc_err_addr  out  ADDR_W  address of most recent error.
REQ-022 SHALL have port sb_err_cnt  out  CNT_W  saturating single-bit error count.

Function
REQ-023 SHALL accept a request in cycle N when req_cs=1 and req_hold=0, driving sram_cs/we/addr combinationally in N.
REQ-024 SHALL, on accepted write, drive sram_wdata = SECDED(39,32) encode of req_wdata in N; no req_rvalid.
REQ-025 SHALL, on accepted read, assert req_rvalid for exactly cycle N+1 with req_rdata decoded from sram_rdata.
REQ-026 SHALL, on zero syndrome, return data unchanged with no error pulse.
REQ-027 SHALL, on single-bit error (data or check bit), return corrected data, pulse ecc_sb_err in N+1, capture address into ecc_err_addr.
REQ-028 SHALL, on double-bit error, return raw data bits, pulse ecc_db_err in N+1, capture address, perform no write-back.
REQ-029 SHALL implement FSM IDLE -> WB on single-bit error with scrub_en=1 in N+1; WB -> IDLE after one cycle.
REQ-030 SHALL assert req_hold combinationally in N+1 when a write-back is scheduled and throughout WB.
REQ-031 SHALL, in WB (cycle N+2), write the registered corrected codeword to the registered address (sram_cs=1, sram_we=1).
REQ-032 SHALL keep req_hold=0 in IDLE otherwise, allowing back-to-back reads every cycle.
REQ-033 SHALL increment sb_err_cnt per single-bit error, saturating at all-ones.
REQ-034 SHALL give cnt_clr priority over a simultaneous increment (result 0).
REQ-035 SHALL drive sram_cs=0 when no accepted request and not in WB.

Reset
REQ-036 SHALL, on mci_rst_b=0, force FSM to IDLE and all registered outputs/state to 0 asynchronously.
REQ-037 SHALL abandon a pending or in-progress write-back on reset; no SRAM write after reset release without a new request.

Structure
REQ-038 SHALL place MCI_SRAM_DATA_W=32, MCI_SRAM_ECC_W=7, codeword width and the FSM state enum in mci_pkg.
REQ-039 SHALL instantiate one sub-module, mci_sram_secded, containing combinational encode and decode/syndrome logic.

Verification
REQ-040 SHALL cover: write 0xDEADBEEF @0x10, read @0x10 -> rvalid next cycle, rdata 0xDEADBEEF, no error pulses.
REQ-041 SHALL cover: flip data bit 5 @0x20, read, scrub_en=1 -> corrected data, ecc_sb_err, hold 2 cycles, write-back to 0x20, re-read clean.
REQ-042 SHALL cover: flip bits 3 and 9 @0x30 -> ecc_db_err, ecc_err_addr=0x30, no SRAM write, sb_err_cnt unchanged.
REQ-043 SHALL cover: CNT_W=4, 16 single-bit reads -> count 0xF holds; cnt_clr with concurrent error -> 0.
REQ-044 SHALL cover: single-bit error, mci_rst_b low during WB -> no write-back, outputs 0, FSM IDLE.
